clk_50_gen: RTL and testbench
=============================

// Module: clk_50_gen
// PURPOSE
//  Clock divider producing the 50 MHz system clock (clkout) from the board clock (clkin).
//  Default divide-by-2 gives 50 MHz from 100 MHz.
//  Also outputs a single-cycle clock-enable pulse (ce_out) in the clkin domain, aligned
//  with each clkout rising edge, so logic can stay on clkin when preferred.
//  Sits at the top level, feeding game/video logic.
// PARAMETERS
//  DIV  2  Integer divide ratio, DIV >= 2; DIV < 2 is a compile-time error.
// PORTS
//  clkin   input   1  Source clock; all flops are clocked by it (rising edge).
//  rst_n   input   1  Reset; one clock; reset is asynchronous and active-low.
//  clkout  output  1  Divided clock, period = DIV * T(clkin).
//  ce_out  output  1  One-clkin-cycle pulse, high in the cycle where clkout rises.
// BEHAVIOUR
//  - Phase counter cnt, width $clog2(DIV), counts clkin rising edges modulo DIV.
//  - Number the clkin rising edges after rst_n deasserts as n = 1, 2, 3, ...
//  - After edge n, with p = (n-1) mod DIV:
//      clkout = (p < DIV/2), using integer division.
//      ce_out = (p == 0).
//    So clkout rises on the first clkin edge after reset release.
//  - Even DIV: exact 50% duty; high DIV/2 cycles, low DIV/2 cycles.
//  - Odd DIV (macro absent): high (DIV-1)/2 cycles, low (DIV+1)/2 cycles.
//  - clkout and ce_out come directly from flops: no combinational glitches, no gating of clkin.
//  - Reset values: cnt = 0, clkout = 0, ce_out = 0, plus the negedge flop when present.
//  - Reset asserted mid-operation: outputs clear immediately (asynchronously), even mid-high-phase.
//    Phase restarts from edge n = 1 after release, with no partial pulses.
//  - Counter wrap: p goes from DIV-1 to 0 on the next edge; clkout and ce_out rise on that same edge.
//  - ce_out for DIV = 2 equals clkout; for DIV > 2 it is high 1 of every DIV cycles.
// CONFIGURATION
//  CLK_50_GEN_ODD_DUTY_EN defined:
//   - Odd DIV only: add a flop clocked on the clkin falling edge that samples clkout.
//   - Output clkout = posedge term OR negedge term.
//   - High time becomes DIV/2 clkin periods exactly (50% duty), e.g. DIV = 3 gives 1.5 high, 1.5 low.
//   - The negedge flop also resets asynchronously to 0.
//   - ce_out timing is unchanged.
//   - For even DIV the macro has no effect; identical logic is generated.
//  Not defined: no negedge logic; odd-DIV duty as stated in BEHAVIOUR.
// TESTING
//  clkin toggles every 1 ns (2 ns period); rst_n is held low 100 ns, then released.
//  1. DIV=2: clkout = 0 throughout reset. On the first clkin rise after release clkout = 1;
//     period 4 ns, high 2 ns, low 2 ns.
//  2. DIV=2: count clkout rising edges over 200 ns after release -> exactly 50;
//     ce_out == clkout every cycle.
//  3. DIV=4: clkout high 4 ns, low 4 ns; ce_out is a 2 ns pulse every 8 ns,
//     starting at each clkout rise.
//  4. Assert rst_n while clkout = 1 (mid-phase) -> clkout and ce_out go 0 at once.
//     After release, the first clkin rise gives clkout = 1 and ce_out = 1.
//  5. DIV=3, macro absent: high 2 ns, low 4 ns. Macro defined: high 3 ns, low 3 ns.
//     Both cases: period 6 ns, ce_out a 2 ns pulse every 6 ns.

Source files
------------

// File: rtl/clk_50_gen.sv
// Divides clkin by DIV into clkout plus a one-cycle clock-enable (ce_out) aligned to clkout rising.
// Optional macro CLK_50_GEN_ODD_DUTY_EN: for odd DIV, widens clkout with a falling-edge flop to give 50% duty.
`timescale 1ns/1ps
module clk_50_gen #(
    parameter int DIV = 2
) (
    input  logic clkin,
    input  logic rst_n,
    output logic clkout,
    output logic ce_out
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    if (DIV < 2) begin : g_bad_div
        $error("clk_50_gen: DIV must be >= 2");
    end

    // cnt holds the phase that the next clkin edge will present on the outputs
    logic [CW-1:0] cnt;
    logic          clk_pos;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_pos <= 1'b0;
            ce_out  <= 1'b0;
        end else begin
            clk_pos <= (cnt < HALF);
            ce_out  <= (cnt == '0);
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

`ifdef CLK_50_GEN_ODD_DUTY_EN
    if (DIV % 2 == 1) begin : g_odd_duty
        // Half-cycle delayed copy stretches the high phase by half a clkin period
        logic clk_neg;

        always_ff @(negedge clkin or negedge rst_n) begin
            if (!rst_n) begin
                clk_neg <= 1'b0;
            end else begin
                clk_neg <= clk_pos;
            end
        end

        assign clkout = clk_pos | clk_neg;
    end else begin : g_even_duty
        assign clkout = clk_pos;
    end
`else
    assign clkout = clk_pos;
`endif

endmodule

// File: tb/tb_clk_50_gen.sv
// Bench for clk_50_gen: three instances (DIV = 2, 4, 3) against a half-period time model.
`timescale 1ns/1ps
module tb_clk_50_gen;
`ifdef CLK_50_GEN_ODD_DUTY_EN
    localparam bit ODD_DUTY = 1'b1;
`else
    localparam bit ODD_DUTY = 1'b0;
`endif

    logic clkin = 1'b0;
    logic rst_n;
    logic clkout2, ce_out2, clkout4, ce_out4, clkout3, ce_out3;

    int errors = 0;
    int checks = 0;
    int rises  = 0;
    logic prev2 = 1'b0;

    // Model: half-periods elapsed since the first clkin rise after reset release
    bit started = 1'b0;
    int h = 0;

    always #1 clkin = ~clkin;

    clk_50_gen #(.DIV(2)) u_div2 (.clkin(clkin), .rst_n(rst_n), .clkout(clkout2), .ce_out(ce_out2));
    clk_50_gen #(.DIV(4)) u_div4 (.clkin(clkin), .rst_n(rst_n), .clkout(clkout4), .ce_out(ce_out4));
    clk_50_gen #(.DIV(3)) u_div3 (.clkin(clkin), .rst_n(rst_n), .clkout(clkout3), .ce_out(ce_out3));

    function automatic logic exp_clk(int d);
        int hi_halves;
        if (!started) return 1'b0;
        hi_halves = (ODD_DUTY && (d % 2 == 1)) ? d : 2 * (d / 2);
        return ((h % (2 * d)) < hi_halves);
    endfunction

    function automatic logic exp_ce(int d);
        if (!started) return 1'b0;
        return ((h % (2 * d)) < 2);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("div2_clkout", clkout2, exp_clk(2));
        check("div2_ce",     ce_out2, exp_ce(2));
        check("div4_clkout", clkout4, exp_clk(4));
        check("div4_ce",     ce_out4, exp_ce(4));
        check("div3_clkout", clkout3, exp_clk(3));
        check("div3_ce",     ce_out3, exp_ce(3));
    endtask

    // Advance k clkin edges, updating the model and checking 0.6 ns after each edge
    task automatic run_halves(input int k, input bit count);
        for (int i = 0; i < k; i++) begin
            @(clkin);
            if (!rst_n) begin
                started = 1'b0;
            end else if (clkin) begin
                if (!started) begin
                    started = 1'b1;
                    h = 0;
                end else begin
                    h++;
                end
            end else if (started) begin
                h++;
            end
            #0.6;
            check_all();
            if (count && !prev2 && clkout2) rises++;
            prev2 = clkout2;
        end
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_clkout2"}, clkout2, 1'b0);
        check({tag, "_ce2"},     ce_out2, 1'b0);
        check({tag, "_clkout4"}, clkout4, 1'b0);
        check({tag, "_ce4"},     ce_out4, 1'b0);
        check({tag, "_clkout3"}, clkout3, 1'b0);
        check({tag, "_ce3"},     ce_out3, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        run_halves(100, 1'b0);
        rst_n = 1'b1;
        #0.2;
        check_reset_zero("post_release");

        prev2 = 1'b0;
        run_halves(200, 1'b1);
        checks++;
        assert (rises == 50) else begin
            errors++;
            $error("FAIL div2_rise_count observed=%0d expected=%0d", rises, 50);
        end

        for (int round = 0; round < 8; round++) begin
            run_halves(int'($urandom_range(10, 120)), 1'b0);
            // Wait (bounded) for the DIV=4 output to be mid-high-phase
            for (int k = 0; k < 16 && !exp_clk(4); k++) run_halves(1, 1'b0);
            check("midphase_div4_high", clkout4, 1'b1);
            #0.1;
            rst_n = 1'b0;
            #0.1;
            check_reset_zero("async_reset");
            run_halves(int'($urandom_range(1, 12)), 1'b0);
            rst_n = 1'b1;
            #0.2;
            check_reset_zero("release");
        end

        run_halves(60, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
